// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial adder: one full-adder cell and a carry flip-flop
//             reused over WIDTH cycles, LSB first, start/busy/done handshake.
//             Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-2:0] psum;

    logic             bit_s;
    logic             bit_c;
    logic             last;
    logic [WIDTH-1:0] psum_nxt;

    // Full-adder cell; the new sum bit enters at the MSB so that after WIDTH
    // shifts the first (LSB) result bit has reached bit 0.
    always_comb begin
        bit_s    = a_sh[0] ^ b_sh[0] ^ carry;
        bit_c    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        last     = (cnt == LAST);
        psum_nxt = {bit_s, psum};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            psum  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        psum  <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= bit_c;
                    psum  <= psum_nxt[WIDTH-1:1];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum  <= psum_nxt;
                        cout <= bit_c;
`ifdef SERIAL_ADDER_OVF_EN
                        // Carry into the MSB is the carry FF on the final bit.
                        ovf  <= carry ^ bit_c;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder: one full-adder cell plus a carry flip-flop, reused over WIDTH clock cycles.
- Adds two WIDTH-bit operands and a carry-in, LSB first, and returns a registered sum and carry-out.
- Uses a start/busy/done handshake.
- Sits in the arithmetic library as the area-minimal successor to the combinational full adder, for datapaths where latency is cheaper than gates.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..64.

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      synchronous active-low reset
- start  input   1      request; sampled only in IDLE
- a      input   WIDTH  operand A; captured on the accepted start edge
- b      input   WIDTH  operand B; captured on the accepted start edge
- cin    input   1      carry-in; captured on the accepted start edge
- busy   output  1      high while in RUN
- done   output  1      one-cycle pulse; result valid
- sum    output  WIDTH  registered result; held until the next result
- cout   output  1      registered carry-out; held with sum

Behaviour:
- One clock. Reset is synchronous and active-low: rst_n sampled low at a rising clk edge resets the block. No asynchronous path.
- Reset values:
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Internal operand shift registers, carry flip-flop and bit counter all 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: load a, b into right-shift registers, carry FF <= cin, counter <= 0, go to RUN. busy=1 from E0.
  - start=0: stay in IDLE. Outputs hold.
- RUN, each edge Ek for k=1..WIDTH:
  - s_k = a_lsb ^ b_lsb ^ carry.
  - carry <= majority(a_lsb, b_lsb, carry).
  - Shift both operands right one place. Shift s_k into the MSB of an internal partial-sum register. counter++.
  - At edge E_WIDTH (counter reaches WIDTH-1 before increment): sum <= completed partial sum (including the bit produced this edge), cout <= final carry, go to DONE, busy=0, done=1.
- DONE: lasts exactly one cycle. At E(WIDTH+1): done=0, go to IDLE.
- Latency: done is high in the cycle after edge E_WIDTH, i.e. WIDTH edges after the accepted start edge. Minimum start-to-start spacing is WIDTH+2 edges (next start accepted at E(WIDTH+2) at the earliest).
- sum and cout change only at E_WIDTH or on reset. They never show partial results and stay stable in RUN, DONE and IDLE.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1); unsigned, exact.
- start while in RUN or DONE: ignored. No queuing, operands not re-captured.
- a/b/cin changing after E0: no effect on the operation in flight.
- Reset mid-RUN: operation aborted. All state and outputs return to reset values at that edge. done never asserts for the aborted operation.
- Reset has priority over start at the same edge.
- Bit counter width: $clog2(WIDTH+1).

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit, reset 0) = signed two's-complement overflow.
  - ovf is the carry into the MSB XOR the carry out of the MSB, captured at E_WIDTH alongside sum/cout and held the same way.
- When undefined: port ovf does not exist; all other behaviour is identical.

Test Plan:
- WIDTH=8, a=0xFF, b=0x01, cin=0, start one cycle -> busy high 8 cycles; done pulse exactly one cycle, 8 edges after the start edge; sum=0x00, cout=1.
- WIDTH=8, a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Then a=0x12, b=0x34, cin=0 -> sum=0x46, cout=0. sum holds 0x00 throughout the second RUN until its E_WIDTH.
- WIDTH=2, exhaustive over all 32 combinations of a, b, cin, back-to-back at minimum spacing -> {cout,sum} equals a+b+cin in every case; scoreboard compare.
- Pulse start again at cycles 3 and 8 of a RUN (WIDTH=8) -> ignored: exactly one done pulse, result from the original operands. Operands toggled mid-run have no effect.
- rst_n=0 for one edge at RUN cycle 4 -> busy=0, done=0, sum=0, cout=0 next cycle. No done pulse follows. A fresh start afterwards computes 0x7F+0x01=0x80, cout=0.
- With SERIAL_ADDER_OVF_EN, WIDTH=8: 0x7F+0x01 -> sum=0x80, ovf=1. 0x80+0x80 -> sum=0x00, cout=1, ovf=1. 0xFF+0x01 -> ovf=0.
